usb2_ep4_ts_reader: RTL and testbench

Drains EP4 (bulk OUT, transport stream from host) packet buffers from the USB 2.0 protocol layer and presents them as a byte stream with valid/ready flow control and 188-byte MPEG-TS packet alignment. Connects to the protocol layer's ep4_buf_out_* port group on the USB side and to the TS output/modulator path on the other. Releases each buffer with the 4-phase arm/arm_ack handshake once every byte has been read.

---
 rtl/usb2_ep4_ts_reader_pkg.sv | 22 ++
 rtl/usb2_ep4_ts_reader_skid_fifo.sv | 59 +++++
 rtl/usb2_ep4_ts_reader.sv | 202 ++++++++++++++++++++
 tb/tb_usb2_ep4_ts_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb2_ep4_ts_reader_pkg.sv
// Shared definitions for the EP4 transport-stream reader: FSM and sync
// encodings plus the TS framing constants.
package usb2_ep4_ts_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_ARM   = 3'd3,
        S_REL   = 3'd4
    } rd_state_t;

    typedef enum logic {
        SYNC_HUNT = 1'b0,
        SYNC_LOCK = 1'b1
    } sync_state_t;

    localparam logic [7:0] TS_SYNC_BYTE    = 8'h47;
    localparam int         TS_LEN_DEFAULT  = 188;
    localparam int         MAX_PKT_DEFAULT = 512;

endpackage

// File: rtl/usb2_ep4_ts_reader_skid_fifo.sv
// Small synchronous FIFO holding {sop, data} between the buffer read pipe
// and the TS output; count is exported so the reader can budget credits.
module usb2_skid_fifo
    import usb2_ep4_ts_reader_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPop;

    assign doPop      = pop_i && (count_q != '0);
    assign pop_data_o = mem_q[rdPtr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= push_data_i;
                wrPtr_q        <= wrPtr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_i, doPop})
                2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usb2_ep4_ts_reader.sv
// Drains EP4 bulk-OUT buffers into a valid/ready byte stream aligned to
// 188-byte TS packets, then releases each buffer with a 4-phase handshake.
module usb2_ep4_ts_reader
    import usb2_ep4_ts_reader_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int MAX_PKT    = MAX_PKT_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_LEN     = TS_LEN_DEFAULT
) (
    input  logic        phy_clk,
    input  logic        reset,
    output logic [8:0]  buf_out_addr,
    input  logic [7:0]  buf_out_q,
    input  logic [10:0] buf_out_len,
    input  logic        buf_out_hasdata,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    input  logic        flush,
    output logic [7:0]  ts_data,
    output logic        ts_valid,
    input  logic        ts_ready,
    output logic        ts_sop,
    output logic [15:0] pkt_count,
    output logic        len_err,
    output logic [7:0]  sync_err_count
);

    localparam int           CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int           IW       = $clog2(TS_LEN);
    localparam logic [10:0]  MAX_LEN  = 11'(MAX_PKT);
    localparam logic [CW:0]  DEPTH_L  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(TS_LEN - 1);

    rd_state_t   state_q, state_d;
    sync_state_t sync_q, sync_d;
    logic [10:0] len_q, len_d;
    logic [10:0] rdPtr_q, rdPtr_d;
    logic [RD_LAT-1:0] inflight_q;
    logic [15:0] pktCount_q, pktCount_d;
    logic        lenErr_q, lenErr_d;
    logic [7:0]  syncErrCount_q, syncErrCount_d;
    logic [IW-1:0] tsIdx_q, tsIdx_d;

    logic          issue;
    logic          hasCredit;
    logic [CW:0]   inflightCnt;
    logic [CW-1:0] fifoCount;
    logic          retValid;
    logic          push;
    logic          pushSop;
    logic [8:0]    fifoHead;

    always_comb begin
        inflightCnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflightCnt = inflightCnt + {{CW{1'b0}}, inflight_q[i]};
        end
    end

    // Reads already in the pipe count against FIFO space, so returning
    // bytes can be written without ever checking for a full FIFO.
    assign hasCredit = (({1'b0, fifoCount} + inflightCnt) < DEPTH_L);
    assign retValid  = inflight_q[RD_LAT-1] && !flush;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rdPtr_d    = rdPtr_q;
        pktCount_d = pktCount_q;
        lenErr_d   = 1'b0;
        issue      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (buf_out_hasdata && !flush) begin
                    rdPtr_d = '0;
                    if (buf_out_len > MAX_LEN) begin
                        len_d    = MAX_LEN;
                        lenErr_d = 1'b1;
                    end else begin
                        len_d = buf_out_len;
                    end
                    state_d = (buf_out_len == '0) ? S_ARM : S_READ;
                end
            end
            S_READ: begin
                if (flush) begin
                    state_d = S_ARM;
                end else if (hasCredit) begin
                    issue   = 1'b1;
                    rdPtr_d = rdPtr_q + 11'd1;
                    if (rdPtr_q == (len_q - 11'd1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (flush || (inflight_q == '0)) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (buf_out_arm_ack) begin
                    pktCount_d = pktCount_q + 16'd1;
                    state_d    = S_REL;
                end
            end
            S_REL: begin
                if (!buf_out_arm_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sync filtering happens before the FIFO so dropped bytes never occupy
    // a slot; their credit is returned simply by leaving the pipe.
    always_comb begin
        sync_d         = sync_q;
        tsIdx_d        = tsIdx_q;
        syncErrCount_d = syncErrCount_q;
        push           = 1'b0;
        pushSop        = 1'b0;
        if (flush) begin
            sync_d  = SYNC_HUNT;
            tsIdx_d = '0;
        end else if (retValid) begin
            if (sync_q == SYNC_HUNT || tsIdx_q == '0) begin
                if (buf_out_q == TS_SYNC_BYTE) begin
                    push    = 1'b1;
                    pushSop = 1'b1;
                    tsIdx_d = IW'(1);
                    sync_d  = SYNC_LOCK;
                end else if (sync_q == SYNC_LOCK) begin
                    sync_d = SYNC_HUNT;
                    if (syncErrCount_q != 8'hFF) begin
                        syncErrCount_d = syncErrCount_q + 8'd1;
                    end
                end
            end else begin
                push    = 1'b1;
                tsIdx_d = (tsIdx_q == IDX_LAST) ? '0 : tsIdx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sync_q         <= SYNC_HUNT;
            len_q          <= '0;
            rdPtr_q        <= '0;
            inflight_q     <= '0;
            pktCount_q     <= '0;
            lenErr_q       <= 1'b0;
            syncErrCount_q <= '0;
            tsIdx_q        <= '0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            len_q          <= len_d;
            rdPtr_q        <= rdPtr_d;
            pktCount_q     <= pktCount_d;
            lenErr_q       <= lenErr_d;
            syncErrCount_q <= syncErrCount_d;
            tsIdx_q        <= tsIdx_d;
            if (flush) begin
                inflight_q <= '0;
            end else begin
                inflight_q[0] <= issue;
                for (int i = 1; i < RD_LAT; i++) begin
                    inflight_q[i] <= inflight_q[i-1];
                end
            end
        end
    end

    usb2_skid_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (phy_clk),
        .rst         (reset),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i ({pushSop, buf_out_q}),
        .pop_i       (ts_valid && ts_ready),
        .pop_data_o  (fifoHead),
        .count_o     (fifoCount)
    );

    assign ts_valid       = (fifoCount != '0);
    assign ts_data        = ts_valid ? fifoHead[7:0] : 8'h00;
    assign ts_sop         = ts_valid && fifoHead[8];
    assign buf_out_addr   = rdPtr_q[8:0];
    assign buf_out_arm    = (state_q == S_ARM);
    assign pkt_count      = pktCount_q;
    assign len_err        = lenErr_q;
    assign sync_err_count = syncErrCount_q;

endmodule

// File: tb/tb_usb2_ep4_ts_reader.sv
// Directed bench for usb2_ep4_ts_reader: a latency-accurate buffer model and
// an auto-acking protocol layer, with hand-derived expectations per step.
`timescale 1ns/1ps
module tb_usb2_ep4_ts_reader;

    localparam int RD_LAT = 2;

    logic        phy_clk = 1'b0;
    logic        reset;
    logic [8:0]  buf_out_addr;
    logic [7:0]  buf_out_q;
    logic [10:0] buf_out_len;
    logic        buf_out_hasdata;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;
    logic        flush;
    logic [7:0]  ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic        ts_sop;
    logic [15:0] pkt_count;
    logic        len_err;
    logic [7:0]  sync_err_count;

    always #5 phy_clk = ~phy_clk;

    usb2_ep4_ts_reader #(
        .RD_LAT     (RD_LAT),
        .MAX_PKT    (512),
        .FIFO_DEPTH (4),
        .TS_LEN     (188)
    ) dut (
        .phy_clk         (phy_clk),
        .reset           (reset),
        .buf_out_addr    (buf_out_addr),
        .buf_out_q       (buf_out_q),
        .buf_out_len     (buf_out_len),
        .buf_out_hasdata (buf_out_hasdata),
        .buf_out_arm     (buf_out_arm),
        .buf_out_arm_ack (buf_out_arm_ack),
        .flush           (flush),
        .ts_data         (ts_data),
        .ts_valid        (ts_valid),
        .ts_ready        (ts_ready),
        .ts_sop          (ts_sop),
        .pkt_count       (pkt_count),
        .len_err         (len_err),
        .sync_err_count  (sync_err_count)
    );

    logic [7:0] mem [0:2047];
    logic [7:0] rdPipe [RD_LAT];

    // Buffer RAM model: data appears RD_LAT cycles after its address.
    always @(posedge phy_clk) begin
        rdPipe[0] <= mem[buf_out_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            rdPipe[i] <= rdPipe[i-1];
        end
    end
    assign buf_out_q = rdPipe[RD_LAT-1];

    int cycleNo = 0;
    always @(posedge phy_clk) cycleNo <= cycleNo + 1;

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;
    int startCycle = 0;
    int armRises = 0;
    int armRiseCycle = 0;
    int lenErrPulses = 0;
    int stallViolations = 0;
    int maxFifo = 0;
    bit randReady = 1'b0;
    bit ackEnable = 1'b1;
    bit stallCheckOn = 1'b0;
    bit prevArm = 1'b0;
    bit prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic [7:0] rxData[$];
    bit         rxSop[$];
    int         rxCycle[$];

    // Protocol-layer responder, downstream sink and observers share one
    // negedge process so ready is settled before the handshake is judged.
    initial begin
        forever begin
            @(negedge phy_clk);
            if (buf_out_arm && !prevArm) begin
                armRises++;
                armRiseCycle = cycleNo;
            end
            prevArm = buf_out_arm;
            if (len_err) lenErrPulses++;
            if (ackEnable) begin
                if (buf_out_arm && !buf_out_arm_ack) begin
                    buf_out_arm_ack = 1'b1;
                    buf_out_hasdata = 1'b0;
                end else if (!buf_out_arm && buf_out_arm_ack) begin
                    buf_out_arm_ack = 1'b0;
                end
            end
            if (stallCheckOn && prevStall && (!ts_valid || ts_data !== prevData))
                stallViolations++;
            if (randReady) ts_ready = 1'($urandom_range(0, 1));
            if (ts_valid && ts_ready) begin
                rxData.push_back(ts_data);
                rxSop.push_back(ts_sop);
                rxCycle.push_back(cycleNo);
            end
            prevStall = ts_valid && !ts_ready;
            prevData  = ts_data;
            if (int'(dut.u_fifo.count_o) > maxFifo) maxFifo = int'(dut.u_fifo.count_o);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearRx();
        rxData.delete();
        rxSop.delete();
        rxCycle.delete();
        armRises = 0;
        lenErrPulses = 0;
        stallViolations = 0;
        maxFifo = 0;
    endtask

    task automatic fillTs(input int len);
        for (int a = 0; a < len; a++) begin
            mem[a] = (a % 188 == 0) ? 8'h47 : 8'((a * 7 + 3) & 255);
        end
    endtask

    task automatic flushPulse();
        @(negedge phy_clk);
        flush = 1'b1;
        @(negedge phy_clk);
        flush = 1'b0;
    endtask

    // Present one buffer and wait (bounded) for its release, then let the
    // FIFO empty out.
    task automatic applyStimulus(input int len, input int expPkt, input string tag);
        int waited;
        @(negedge phy_clk);
        buf_out_len     = 11'(len);
        buf_out_hasdata = 1'b1;
        startCycle      = cycleNo;
        waited = 0;
        while (pkt_count != 16'(expPkt) && waited < 6000) begin
            @(negedge phy_clk);
            waited++;
        end
        checkOutput({tag, "_pkt_count"}, 32'(pkt_count), 32'(expPkt));
        repeat (40) @(negedge phy_clk);
    endtask

    task automatic compareStream(input string tag, input int offset, input int expCount);
        int mism;
        mism = 0;
        checkOutput({tag, "_byte_count"}, 32'(rxData.size()), 32'(expCount));
        for (int i = 0; i < rxData.size() && i < expCount; i++) begin
            if (rxData[i] !== mem[offset + i]) mism++;
        end
        checkOutput({tag, "_data_mismatches"}, 32'(mism), 32'd0);
    endtask

    function automatic int countSops();
        int n;
        n = 0;
        foreach (rxSop[i]) if (rxSop[i]) n++;
        return n;
    endfunction

    initial begin
        int waited;
        reset = 1'b1;
        buf_out_len = '0;
        buf_out_hasdata = 1'b0;
        buf_out_arm_ack = 1'b0;
        flush = 1'b0;
        ts_ready = 1'b1;
        for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
        repeat (3) @(negedge phy_clk);

        checkOutput("rst_ts_valid", 32'(ts_valid), 32'd0);
        checkOutput("rst_arm", 32'(buf_out_arm), 32'd0);
        checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("rst_len_err", 32'(len_err), 32'd0);
        checkOutput("rst_sync_err", 32'(sync_err_count), 32'd0);
        checkOutput("rst_addr", 32'(buf_out_addr), 32'd0);
        checkOutput("rst_ts_data", 32'(ts_data), 32'd0);
        checkOutput("rst_ts_sop", 32'(ts_sop), 32'd0);
        @(negedge phy_clk);
        reset = 1'b0;
        repeat (2) @(negedge phy_clk);

        $display("[TB] step 1: two TS packets, ready held high");
        fillTs(376);
        clearRx();
        applyStimulus(376, 1, "two_pkt");
        compareStream("two_pkt", 0, 376);
        checkOutput("two_pkt_sop0", 32'(rxSop[0]), 32'd1);
        checkOutput("two_pkt_sop188", 32'(rxSop[188]), 32'd1);
        checkOutput("two_pkt_sop_count", 32'(countSops()), 32'd2);
        checkOutput("two_pkt_first_latency", 32'(rxCycle[0] - startCycle), 32'(RD_LAT + 2));
        checkOutput("two_pkt_contiguous", 32'(rxCycle[375] - rxCycle[0]), 32'd375);
        checkOutput("two_pkt_arm_rises", 32'(armRises), 32'd1);
        checkOutput("two_pkt_arm_after_last", 32'(armRiseCycle > rxCycle[375]), 32'd1);
        checkOutput("two_pkt_len_err", 32'(lenErrPulses), 32'd0);

        $display("[TB] step 2: empty buffer");
        clearRx();
        applyStimulus(0, 2, "empty");
        checkOutput("empty_no_bytes", 32'(rxData.size()), 32'd0);
        checkOutput("empty_arm_rises", 32'(armRises), 32'd1);

        $display("[TB] step 3: full buffer, random ready");
        flushPulse();
        fillTs(512);
        clearRx();
        stallCheckOn = 1'b1;
        randReady = 1'b1;
        applyStimulus(512, 3, "random");
        randReady = 1'b0;
        stallCheckOn = 1'b0;
        ts_ready = 1'b1;
        compareStream("random", 0, 512);
        checkOutput("random_stall_stable", 32'(stallViolations), 32'd0);
        checkOutput("random_fifo_le4", 32'(maxFifo <= 4), 32'd1);
        checkOutput("random_sop_count", 32'(countSops()), 32'd3);

        $display("[TB] step 4: oversize buffer clamps");
        flushPulse();
        fillTs(700);
        clearRx();
        applyStimulus(700, 4, "oversize");
        compareStream("oversize", 0, 512);
        checkOutput("oversize_len_err_pulses", 32'(lenErrPulses), 32'd1);

        $display("[TB] step 5: sync hunt and loss");
        flushPulse();
        fillTs(191);
        mem[0] = 8'h00;
        mem[1] = 8'h12;
        mem[2] = 8'h47;
        for (int a = 3; a < 190; a++) mem[a] = 8'((a * 5 + 1) & 255);
        mem[190] = 8'h55;
        clearRx();
        applyStimulus(191, 5, "sync");
        compareStream("sync", 2, 188);
        checkOutput("sync_sop_first", 32'(rxSop[0]), 32'd1);
        checkOutput("sync_sop_count", 32'(countSops()), 32'd1);
        checkOutput("sync_err_count", 32'(sync_err_count), 32'd1);
        mem[0] = 8'h11;
        mem[1] = 8'h47;
        mem[2] = 8'h22;
        clearRx();
        applyStimulus(3, 6, "rehunt");
        compareStream("rehunt", 1, 2);
        checkOutput("rehunt_sop", 32'(rxSop[0]), 32'd1);

        $display("[TB] step 6: flush in the middle of a read");
        flushPulse();
        fillTs(400);
        clearRx();
        @(negedge phy_clk);
        buf_out_len = 11'd400;
        buf_out_hasdata = 1'b1;
        repeat (99) @(negedge phy_clk);
        ts_ready = 1'b0;
        repeat (2) @(negedge phy_clk);
        checkOutput("flush_fifo_full_before", 32'(ts_valid), 32'd1);
        flush = 1'b1;
        @(negedge phy_clk);
        flush = 1'b0;
        checkOutput("flush_fifo_empty_after", 32'(ts_valid), 32'd0);
        ts_ready = 1'b1;
        waited = 0;
        while (pkt_count != 16'd7 && waited < 200) begin
            @(negedge phy_clk);
            waited++;
        end
        checkOutput("flush_pkt_count", 32'(pkt_count), 32'd7);
        checkOutput("flush_arm_rises", 32'(armRises), 32'd1);
        checkOutput("flush_rx_ge90", 32'(rxData.size() >= 90 && rxData.size() < 110), 32'd1);
        compareStream("flush_prefix", 0, rxData.size());
        repeat (10) @(negedge phy_clk);
        mem[0] = 8'h33;
        mem[1] = 8'h47;
        mem[2] = 8'h99;
        clearRx();
        applyStimulus(3, 8, "post_flush");
        compareStream("post_flush", 1, 2);
        checkOutput("post_flush_sop", 32'(rxSop[0]), 32'd1);

        $display("[TB] step 7: async reset while arm is held");
        mem[0] = 8'h47;
        ackEnable = 1'b0;
        @(negedge phy_clk);
        buf_out_len = 11'd1;
        buf_out_hasdata = 1'b1;
        waited = 0;
        while (!buf_out_arm && waited < 50) begin
            @(negedge phy_clk);
            waited++;
        end
        checkOutput("rst_mid_arm_reached", 32'(buf_out_arm), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_arm_low", 32'(buf_out_arm), 32'd0);
        checkOutput("rst_mid_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("rst_mid_sync_err", 32'(sync_err_count), 32'd0);
        @(negedge phy_clk);
        reset = 1'b0;
        clearRx();
        ackEnable = 1'b1;
        waited = 0;
        while (pkt_count != 16'd1 && waited < 200) begin
            @(negedge phy_clk);
            waited++;
        end
        repeat (10) @(negedge phy_clk);
        checkOutput("reread_pkt_count", 32'(pkt_count), 32'd1);
        compareStream("reread", 0, 1);
        checkOutput("reread_sop", 32'(rxSop[0]), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
